// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi
//  Description : Multi-channel ESC-style PWM generator with arm/disarm
//                sequencing. A prescaler produces a 1 us tick and a us counter
//                defines the frame. Each channel has a shadow register, written
//                by the update strobe, and an active register, loaded only at
//                the frame wrap. Pulses therefore never change mid-frame.
//  Ports       : clock        - single clock
//                reset_n      - asynchronous active-low reset
//                arm          - level request to arm the outputs
//                idle         - level; forces IDLE_US on all channels
//                throttle     - 8 bits per channel, channel i at [8i+7:8i]
//                update       - one-cycle strobe that captures throttle
//                pwm          - registered pulse outputs, one per channel
//                armed        - high only in state ARMED
//                frame_start  - one-cycle pulse after each frame wrap
//                fault        - failsafe timeout flag
//  Options     : PWM_FAILSAFE_EN - when defined, adds a frames-since-update
//                counter that disarms and latches fault on timeout.
//                When undefined, fault is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi #(
    parameter int NUM_CH         = 4,
    parameter int CLK_DIV        = 50,
    parameter int PERIOD_US      = 2500,
    parameter int MIN_US         = 1064,
    parameter int SPAN_US        = 803,
    parameter int IDLE_US        = 900,
    parameter int ARM_FRAMES     = 400,
    parameter int TIMEOUT_FRAMES = 40
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  idle,
    input  logic [8*NUM_CH-1:0]   throttle,
    input  logic                  update,
    output logic [NUM_CH-1:0]     pwm,
    output logic                  armed,
    output logic                  frame_start,
    output logic                  fault
);

    // One width holds every microsecond quantity (counter, shadow, active).
    localparam int c_PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_W      = $clog2(PERIOD_US + MIN_US + SPAN_US + IDLE_US + 1);
    localparam int c_PROD_W = 8 + $clog2(SPAN_US + 1);
    localparam int c_FR_W   = (ARM_FRAMES > 0) ? $clog2(ARM_FRAMES + 1) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_MAX = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_W-1:0]      c_US_MAX  = c_W'(PERIOD_US - 1);
    localparam logic [c_W-1:0]      c_MIN     = c_W'(MIN_US);
    localparam logic [c_W-1:0]      c_IDLE    = c_W'(IDLE_US);
    localparam logic [c_PROD_W-1:0] c_SPAN    = c_PROD_W'(SPAN_US);
    localparam logic [c_FR_W-1:0]   c_ARM     = c_FR_W'(ARM_FRAMES);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_armed;
    logic [c_FR_W-1:0]   r_frames;
    logic [c_PRE_W-1:0]  r_pre;
    logic [c_W-1:0]      r_us;
    logic                r_frame_start;
    logic [NUM_CH-1:0]   r_pwm;
    logic [c_W-1:0]      r_shadow [NUM_CH];
    logic [c_W-1:0]      r_active [NUM_CH];
    logic [c_W-1:0]      w_mapped [NUM_CH];

    logic w_tick;
    logic w_wrap;
    logic w_load_live;
    logic w_timeout;
    logic w_rearm_block;

    assign w_tick      = (r_pre == c_PRE_MAX);
    assign w_wrap      = w_tick && (r_us == c_US_MAX);
    assign w_load_live = (r_state == ST_ARMED) && !idle;

    // ------------------------------------------------------------------
    // Timebase: 1 us prescaler, frame counter and registered wrap pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre         <= '0;
            r_us          <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_tick) begin
                r_pre <= '0;
                r_us  <= (r_us == c_US_MAX) ? '0 : r_us + c_W'(1);
            end else begin
                r_pre <= r_pre + c_PRE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Throttle mapping: the product is kept at full width before the
    // shift so that 255 maps to MIN_US + 799 rather than a truncated value.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_map
        assign w_mapped[gi] = c_MIN +
            c_W'((c_PROD_W'(throttle[8*gi +: 8]) * c_SPAN) >> 8);
    end

    // ------------------------------------------------------------------
    // Per-channel shadow/active registers and pulse output.
    // active only changes at the wrap (while us_ctr returns to 0), so the
    // comparison below cannot produce a runt or split pulse. An update in
    // the wrap cycle lands in shadow after active has sampled the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_shadow[ch] <= c_MIN;
                r_active[ch] <= c_IDLE;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (update) begin
                    r_shadow[ch] <= w_mapped[ch];
                end
                if (w_wrap) begin
                    r_active[ch] <= w_load_live ? r_shadow[ch] : c_IDLE;
                end
                r_pwm[ch] <= (r_us < r_active[ch]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arming state machine. The frame count stops at ARM_FRAMES because
    // the transition to ARMED takes priority over further increments.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_DISARMED;
            r_armed  <= 1'b0;
            r_frames <= '0;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    if (arm && !w_rearm_block) begin
                        r_state  <= ST_ARMING;
                        r_frames <= '0;
                    end
                end
                ST_ARMING: begin
                    if (!arm) begin
                        r_state <= ST_DISARMED;
                    end else if (r_frames == c_ARM) begin
                        r_state <= ST_ARMED;
                        r_armed <= 1'b1;
                    end else if (w_wrap) begin
                        r_frames <= r_frames + c_FR_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (!arm || w_timeout) begin
                        r_state <= ST_DISARMED;
                        r_armed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_DISARMED;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWM_FAILSAFE_EN
    // ------------------------------------------------------------------
    // Failsafe: frames since the last update, saturating at the timeout.
    // fault latches on timeout in ARMED and only clears once arm is low,
    // so the operator has to cycle arm before the outputs can rearm.
    // ------------------------------------------------------------------
    localparam int c_TO_W = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
    localparam logic [c_TO_W-1:0] c_TO = c_TO_W'(TIMEOUT_FRAMES);

    logic [c_TO_W-1:0] r_since;
    logic              r_fault;

    assign w_timeout     = (r_state == ST_ARMED) && (r_since == c_TO);
    assign w_rearm_block = r_fault;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_since <= '0;
            r_fault <= 1'b0;
        end else begin
            if (update) begin
                r_since <= '0;
            end else if (w_wrap && (r_since != c_TO)) begin
                r_since <= r_since + c_TO_W'(1);
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end else if (!arm) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign fault = r_fault;
`else
    assign w_timeout     = 1'b0;
    assign w_rearm_block = 1'b0;
    assign fault         = 1'b0;
`endif

    assign pwm         = r_pwm;
    assign armed       = r_armed;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi
//  Description : Directed self-checking bench for pwm_multi. Uses a short
//                frame (1900 us at 2 clocks/us) and ARM_FRAMES=2 so the whole
//                arm / update / idle / disarm sequence fits in a short run.
//                A negedge monitor measures each channel's high time between
//                consecutive frame_start pulses, in clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int NCH   = 4;
    localparam int CDIV  = 2;
    localparam int PER   = 1900;
    localparam int ARMF  = 2;
    localparam int TOF   = 6;
    localparam int P_CYC = CDIV * PER;

    logic              clock    = 1'b0;
    logic              reset_n  = 1'b0;
    logic              arm      = 1'b0;
    logic              idle     = 1'b0;
    logic              update   = 1'b0;
    logic [8*NCH-1:0]  throttle = '0;
    logic [NCH-1:0]    pwm;
    logic              armed;
    logic              frame_start;
    logic              fault;

    int n_checks = 0;
    int n_errors = 0;

    int hi_cnt [NCH];
    int width  [NCH];
    int per_cnt = 0;
    int period  = 0;
    int frames  = 0;

    always #5 clock = ~clock;

    pwm_multi #(
        .NUM_CH         (NCH),
        .CLK_DIV        (CDIV),
        .PERIOD_US      (PER),
        .MIN_US         (1064),
        .SPAN_US        (803),
        .IDLE_US        (900),
        .ARM_FRAMES     (ARMF),
        .TIMEOUT_FRAMES (TOF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .arm         (arm),
        .idle        (idle),
        .throttle    (throttle),
        .update      (update),
        .pwm         (pwm),
        .armed       (armed),
        .frame_start (frame_start),
        .fault       (fault)
    );

    // Width/period monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
            per_cnt = 0;
        end else if (frame_start) begin
            for (int c = 0; c < NCH; c++) begin
                width[c]  = hi_cnt[c];
                hi_cnt[c] = int'(pwm[c]);
            end
            period  = per_cnt;
            per_cnt = 1;
            frames++;
        end else begin
            for (int c = 0; c < NCH; c++) hi_cnt[c] += int'(pwm[c]);
            per_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_frame();
        int start;
        int n;
        start = frames;
        n = 0;
        while (frames == start && n < 2 * P_CYC) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("frame_seen", 32'(frames != start), 1);
    endtask

    // Expected widths are given in us and compared in clock cycles.
    task automatic check_w(input string tag, input int e0, input int e1,
                           input int e2, input int e3);
        int e [NCH];
        e = '{e0, e1, e2, e3};
        for (int c = 0; c < NCH; c++)
            check($sformatf("%s_ch%0d", tag, c), width[c], e[c] * CDIV);
    endtask

    task automatic strobe(input logic [8*NCH-1:0] thr);
        throttle = thr;
        update   = 1'b1;
        @(posedge clock);
        #1;
        update   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_pwm", pwm, 0);
        check("rst_armed", armed, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_fault", fault, 0);
        reset_n = 1'b1;

        // Disarmed: idle pulses every frame
        wait_frame();
        check_w("idle0", 900, 900, 900, 900);
        wait_frame();
        check_w("idle1", 900, 900, 900, 900);
        check("period_idle", period, P_CYC);
        check("armed_off", armed, 0);

        // ch0=0 -> 1064, ch1=128 -> 1465, ch2=255 -> 1863, ch3=64 -> 1264
        strobe({8'd64, 8'd255, 8'd128, 8'd0});
        arm = 1'b1;
        wait_frame();
        check("arming_wait", armed, 0);
        wait_frame();
        cycles(2);
        check("armed_on", armed, 1);
        check("fault_low", fault, 0);
        wait_frame();
        check_w("arm_first", 900, 900, 900, 900);
        wait_frame();
        check_w("mapped", 1064, 1465, 1863, 1264);
        check("period_armed", period, P_CYC);

        // Mid-frame update: current frame keeps the old width
        cycles(1000);
        strobe({8'd64, 8'd255, 8'd128, 8'd255});
        wait_frame();
        check_w("mid_cur", 1064, 1465, 1863, 1264);

        // Update exactly in the wrap cycle: one extra frame of the old value
        cycles(P_CYC - 2);
        throttle = {8'd64, 8'd255, 8'd128, 8'd128};
        update   = 1'b1;
        @(posedge clock);
        #1;
        update   = 1'b0;
        check("wrap_align", frame_start, 1);
        wait_frame();
        check_w("mid_next", 1863, 1465, 1863, 1264);
        wait_frame();
        check_w("wrap_hold", 1863, 1465, 1863, 1264);
        wait_frame();
        check_w("wrap_next", 1465, 1465, 1863, 1264);

        // idle forces IDLE_US from the next frame, then mapped widths return
        cycles(100);
        idle = 1'b1;
        wait_frame();
        check_w("idle_pend", 1465, 1465, 1863, 1264);
        cycles(100);
        idle = 1'b0;
        wait_frame();
        check_w("idle_forced", 900, 900, 900, 900);
        check("armed_idle", armed, 1);

        // Drop arm at us 500 of the 1863 us pulse
        cycles(1000);
        check("ch2_high_at_drop", pwm[2], 1);
        arm = 1'b0;
        cycles(2);
        check("arm_drop", armed, 0);
        wait_frame();
        check_w("drop_done", 1465, 1465, 1863, 1264);
        wait_frame();
        check_w("drop_idle", 900, 900, 900, 900);
        check("period_drop", period, P_CYC);

`ifdef PWM_FAILSAFE_EN
        // No update since long ago: timeout fires as soon as ARMED is reached
        arm = 1'b1;
        wait_frame();
        wait_frame();
        cycles(3);
        check("fs_fault", fault, 1);
        check("fs_disarmed", armed, 0);
        cycles(20);
        check("fs_block", armed, 0);
        arm = 1'b0;
        cycles(2);
        check("fs_clear", fault, 0);
`else
        check("no_fault", fault, 0);
`endif

        // Asynchronous reset forces pwm low without a clock edge
        cycles(10);
        #1;
        check("pre_rst_pwm", pwm, 4'hF);
        reset_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm, 0);
        check("async_rst_fs", frame_start, 0);
        check("async_rst_armed", armed, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of PWM output channels.
REQ-002 SHALL have parameter CLK_DIV, default 50, meaning clock cycles per 1 us tick (50 MHz clock).
REQ-003 SHALL have parameter PERIOD_US, default 2500, meaning the frame period in us (400 Hz).
REQ-004 SHALL have parameters MIN_US=1064, SPAN_US=803 and IDLE_US=900, meaning the throttle-0 pulse, the mapping span and the idle/disarmed pulse, all in us.
REQ-005 SHALL have parameters ARM_FRAMES, default 400, and TIMEOUT_FRAMES, default 40.
REQ-006 SHALL have port clock, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port arm, input, 1 bit: level request to arm the outputs.
REQ-009 SHALL have port idle, input, 1 bit: level; forces IDLE_US on all channels.
REQ-010 SHALL have port throttle, input, 8*NUM_CH bits: channel i occupies bits [8i+7:8i].
REQ-011 SHALL have port update, input, 1 bit: one-cycle strobe to capture throttle.
REQ-012 SHALL have port pwm, output, NUM_CH bits: registered pulse outputs.
REQ-013 SHALL have port armed, output, 1 bit: high only in state ARMED.
REQ-014 SHALL have port frame_start, output, 1 bit: one-cycle pulse at each frame wrap.
REQ-015 SHALL have port fault, output, 1 bit: failsafe timeout flag.

Function
REQ-016 SHALL run a prescaler 0..CLK_DIV-1; tick asserts for the one cycle in which the prescaler equals CLK_DIV-1.
REQ-017 SHALL run a us counter 0..PERIOD_US-1 that advances on tick; frame_start SHALL assert in the cycle after the counter wraps from PERIOD_US-1 to 0.
REQ-018 SHALL compute mapped_i = MIN_US + ((throttle_i * SPAN_US) >> 8) with a full-width product before the shift (throttle 0 -> 1064, throttle 255 -> 1863).
REQ-019 SHALL write mapped_i into shadow_i on the cycle after update is high.
REQ-020 SHALL load active_i at each frame wrap, from shadow_i if the state is ARMED and idle is low, otherwise from IDLE_US.
REQ-021 SHALL apply an update coincident with a frame wrap from the following frame; the current frame uses the previous shadow.
REQ-022 SHALL drive pwm[i] high from the clock after each frame wrap while us_ctr < active_i; the output is registered with 1 cycle latency, so no runt or split pulse occurs mid-frame.
REQ-023 SHALL implement an FSM with states DISARMED, ARMING and ARMED.
REQ-024 SHALL, in DISARMED, move to ARMING when arm=1, clearing the frame count.
REQ-025 SHALL, in ARMING, move to DISARMED when arm=0, and to ARMED when the frame count reaches ARM_FRAMES and arm=1.
REQ-026 SHALL, in ARMED, move to DISARMED when arm=0; the pulse in progress completes and IDLE_US applies from the next frame.
REQ-027 SHALL saturate the frame count at ARM_FRAMES.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously clear the prescaler, us_ctr, pwm, armed, frame_start and fault, set state to DISARMED, set shadow_i to MIN_US and set active_i to IDLE_US.
REQ-029 SHALL, on deassertion mid-frame, restart the frame at us_ctr=0 with an IDLE_US pulse; reset_n=0 forces pwm to 0 immediately.

Configuration
REQ-030 SHALL, with PWM_FAILSAFE_EN defined, count frames since the last update; in ARMED, when the count reaches TIMEOUT_FRAMES, set fault=1 and enter DISARMED.
REQ-031 SHALL, with PWM_FAILSAFE_EN defined, clear fault only when arm=0 and block rearming while fault=1.
REQ-032 SHALL, without PWM_FAILSAFE_EN, tie fault to 0 and omit the timeout counter.

Verification
REQ-033 Release reset with arm=0 -> every 2500 us, all channels pulse 900 us, frame_start pulses once per frame, armed=0.
REQ-034 Hold arm=1 for 400 frames with throttle ch0=0, ch1=128, ch2=255 and update strobed -> armed=1 at frame 400, then pulses of 1064, 1465 and 1863 us.
REQ-035 Strobe update to ch0=255 mid-frame, then strobe on the cycle of a frame wrap -> the current pulse is unchanged and the new width appears at the next or next-but-one frame respectively.
REQ-036 Drop arm at us 500 of a 1863 us pulse -> the pulse completes at 1863 us, the next frame is 900 us and armed falls.
REQ-037 Assert idle while armed -> 900 us pulses from the next frame; deassert idle -> the mapped width returns.
REQ-038 With PWM_FAILSAFE_EN, armed and no update for 40 frames -> fault=1, DISARMED and 900 us pulses; arm=0 clears fault.
